// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division, one bit per
// cycle over DATA_WIDTH cycles. A final cycle applies sign correction and
// writes HI/LO. MTHI/MTLO writes are accepted only while idle.
module mul_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  input  logic                  hi_wen,
  input  logic                  lo_wen,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           is_div_q, is_div_d;
  logic [2*W-1:0] pq_q, pq_d;       // mult: {acc, multiplier}; div: {rem, quotient}
  logic [W-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic           neg_res_q, neg_res_d;
  logic           neg_rem_q, neg_rem_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic           done_q, done_d;

  // Operand magnitudes and sign flags captured at the start edge.
  logic           a_neg, b_neg, b_zero;
  logic [W-1:0]   a_abs, b_abs;

  // Per-iteration datapath.
  logic [W:0]     msum;
  logic [2*W-1:0] mul_next;
  logic           dfit;
  logic [W-1:0]   rsub;
  logic [2*W-1:0] div_next;

  // Result correction.
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix;

  // Operand conditioning and one multiply / divide iteration step.
  always_comb begin
    a_neg  = op[0] & src_a[W-1];
    b_neg  = op[0] & src_b[W-1];
    b_zero = (src_b == '0);
    a_abs  = a_neg ? -src_a : src_a;
    b_abs  = b_neg ? -src_b : src_b;

    msum     = {1'b0, pq_q[2*W-1:W]} + (pq_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {msum, pq_q[W-1:1]};

    // Trial remainder is W+1 bits wide; the difference always fits in W bits when it fits.
    dfit     = (pq_q[2*W-1:W-1] >= {1'b0, opnd_q});
    rsub     = pq_q[2*W-2:W-1] - opnd_q;
    div_next = {(dfit ? rsub : pq_q[2*W-2:W-1]), pq_q[W-2:0], dfit};

    prod_fix = neg_res_q ? -pq_q : pq_q;
    quo_fix  = neg_res_q ? -pq_q[W-1:0] : pq_q[W-1:0];
    rem_fix  = neg_rem_q ? -pq_q[2*W-1:W] : pq_q[2*W-1:W];
  end

  // Next-state logic: IDLE accepts start and MTHI/MTLO, RUN iterates, FIX writes HI/LO.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    pq_d      = pq_q;
    opnd_d    = opnd_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hi_wen) hi_d = wdata;
        if (lo_wen) lo_d = wdata;
        if (start) begin
          state_d   = S_RUN;
          cnt_d     = '0;
          is_div_d  = op[1];
          opnd_d    = op[1] ? b_abs : a_abs;
          pq_d      = {{W{1'b0}}, (op[1] ? a_abs : b_abs)};
          // Divide by zero keeps an all-ones quotient; the dividend-signed remainder restores src_a.
          neg_res_d = op[0] & (src_a[W-1] ^ src_b[W-1]) & ~(op[1] & b_zero);
          neg_rem_d = op[1] & a_neg;
        end
      end
      S_RUN: begin
        pq_d  = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*W-1:W];
          lo_d = prod_fix[W-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      pq_q      <= '0;
      opnd_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      pq_q      <= pq_d;
      opnd_q    <= opnd_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
